// File: rtl/npu_shell_pkg.sv
// Shared definitions for the NPU shell: MMIO map, opcodes, status bits,
// FSM states and descriptor layout.
package npu_shell_pkg;

  localparam int MMIO_ADDR_W = 12;
  localparam int DATA_W      = 32;
  localparam int AXI_DW      = 256;
  localparam int IRQ_W       = 3;

  localparam logic [MMIO_ADDR_W-1:0] REG_DOORBELL   = 12'h000;
  localparam logic [MMIO_ADDR_W-1:0] REG_CQ_BASE_LO = 12'h010;
  localparam logic [MMIO_ADDR_W-1:0] REG_CQ_BASE_HI = 12'h014;
  localparam logic [MMIO_ADDR_W-1:0] REG_CQ_SIZE    = 12'h018;
  localparam logic [MMIO_ADDR_W-1:0] REG_CQ_HEAD    = 12'h01C;
  localparam logic [MMIO_ADDR_W-1:0] REG_CQ_TAIL    = 12'h020;
  localparam logic [MMIO_ADDR_W-1:0] REG_IRQ_STATUS = 12'h024;
  localparam logic [MMIO_ADDR_W-1:0] REG_IRQ_ENABLE = 12'h028;

  localparam logic [7:0] OP_DMA_COPY     = 8'h01;
  localparam logic [7:0] OP_GEMM         = 8'h10;
  localparam logic [7:0] OP_EVENT_SIGNAL = 8'h20;
  localparam logic [7:0] OP_EVENT_WAIT   = 8'h21;

  localparam int ST_CQ_EMPTY   = 0;
  localparam int ST_EVENT      = 1;
  localparam int ST_BAD_OPCODE = 2;

  // Byte offsets inside a 32-byte little-endian descriptor.
  localparam int DESC_OPCODE = 0;
  localparam int DESC_ARG    = 2;
  localparam int DESC_SRC    = 8;
  localparam int DESC_DST    = 16;
  localparam int DESC_BYTES  = 24;
  localparam logic [31:0] DESC_STRIDE = 32'd32;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_DMA_REQ, S_COPY, S_GEMM, S_EVT_WAIT, S_ADVANCE
  } state_t;

  typedef enum logic [2:0] {C_IDLE, C_AR, C_R, C_AW, C_W, C_B} copy_state_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  arg;
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] bytes;
  } desc_t;

  function automatic desc_t unpack_desc(input logic [AXI_DW-1:0] raw);
    desc_t d;
    d.opcode = raw[8*DESC_OPCODE +: 8];
    d.arg    = raw[8*DESC_ARG    +: 8];
    d.src    = raw[8*DESC_SRC    +: 64];
    d.dst    = raw[8*DESC_DST    +: 64];
    d.bytes  = raw[8*DESC_BYTES  +: 32];
    return d;
  endfunction

  // Byte-enable mask for a final beat carrying n (1..31) bytes.
  function automatic logic [31:0] last_strb(input logic [4:0] n);
    return (32'h1 << n) - 32'h1;
  endfunction

endpackage

// File: rtl/npu_axi_copy.sv
// Beat-serial AXI4 copy engine: one AR/R then one AW/W/B per 32-byte beat,
// strictly sequential, pulsing done after the last write response.
module npu_axi_copy
  import npu_shell_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [63:0]       src,
  input  logic [63:0]       dst,
  input  logic [31:0]       bytes,
  output logic              done,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [63:0]       m_axi_awaddr,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [AXI_DW-1:0] m_axi_wdata,
  output logic [31:0]       m_axi_wstrb,
  output logic              m_axi_wlast,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [63:0]       m_axi_araddr,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [AXI_DW-1:0] m_axi_rdata
);

  copy_state_t state;
  logic [31:0] rem;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= C_IDLE;
      done          <= 1'b0;
      rem           <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wlast   <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        C_IDLE: if (start) begin
          if (bytes == 32'd0) begin
            done <= 1'b1;
          end else begin
            m_axi_araddr  <= src;
            m_axi_awaddr  <= dst;
            rem           <= bytes;
            m_axi_arvalid <= 1'b1;
            state         <= C_AR;
          end
        end
        C_AR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
          state         <= C_R;
        end
        C_R: if (m_axi_rvalid) begin
          m_axi_rready  <= 1'b0;
          m_axi_wdata   <= m_axi_rdata;
          m_axi_wstrb   <= (rem >= 32'd32) ? '1 : last_strb(rem[4:0]);
          m_axi_awvalid <= 1'b1;
          state         <= C_AW;
        end
        C_AW: if (m_axi_awready) begin
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b1;
          m_axi_wlast   <= 1'b1;
          state         <= C_W;
        end
        C_W: if (m_axi_wready) begin
          m_axi_wvalid <= 1'b0;
          m_axi_wlast  <= 1'b0;
          m_axi_bready <= 1'b1;
          state        <= C_B;
        end
        C_B: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          if (rem <= 32'd32) begin
            done  <= 1'b1;
            state <= C_IDLE;
          end else begin
            rem           <= rem - 32'd32;
            m_axi_araddr  <= m_axi_araddr + 64'd32;
            m_axi_awaddr  <= m_axi_awaddr + 64'd32;
            m_axi_arvalid <= 1'b1;
            state         <= C_AR;
          end
        end
        default: state <= C_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/npu_shell_top.sv
// NPU shell: MMIO register file, command-queue fetch/decode FSM and the
// stub opcode handlers around the AXI copy engine.
module npu_shell_top
  import npu_shell_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [MMIO_ADDR_W-1:0] mmio_addr,
  input  logic                   mmio_we,
  input  logic [DATA_W-1:0]      mmio_wdata,
  output logic [DATA_W-1:0]      mmio_rdata,
  output logic                   irq,
  output logic                   dma_req_valid,
  output logic [63:0]            dma_req_src,
  output logic [63:0]            dma_req_dst,
  output logic [31:0]            dma_req_bytes,
  input  logic                   dma_req_ready,
  input  logic                   dma_resp_done,
  output logic [63:0]            cq_mem_addr,
  input  logic [AXI_DW-1:0]      cq_mem_rdata,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [63:0]            m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  output logic [AXI_DW-1:0]      m_axi_wdata,
  output logic [31:0]            m_axi_wstrb,
  output logic                   m_axi_wlast,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  output logic [63:0]            m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  input  logic [AXI_DW-1:0]      m_axi_rdata,
  input  logic                   m_axi_rlast
);

  state_t            state;
  desc_t             desc;
  logic              armed;
  logic [31:0]       cq_base_lo, cq_base_hi, cq_size, cq_tail, head, next_head;
  logic [IRQ_W-1:0]  irq_status, irq_enable, status_set, status_clr;
  logic [7:0]        events;
  logic [1:0]        gcnt;
  logic              copy_start, copy_done, bad_op, doorbell;
  logic              unused_ok;

  assign unused_ok     = ^{dma_resp_done, m_axi_rlast, cq_mem_rdata, desc.arg[7:3]};
  assign cq_mem_addr   = {cq_base_hi, cq_base_lo} + {32'd0, head};
  assign dma_req_src   = desc.src;
  assign dma_req_dst   = desc.dst;
  assign dma_req_bytes = desc.bytes;
  assign irq           = |(irq_status & irq_enable);
  assign m_axi_awlen   = 8'd0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_awsize  = 3'd5;
  assign m_axi_arsize  = 3'd5;
  assign doorbell      = mmio_we && (mmio_addr == REG_DOORBELL) && mmio_wdata[0];
  assign status_clr    = (mmio_we && mmio_addr == REG_IRQ_STATUS) ? mmio_wdata[IRQ_W-1:0] : '0;
  assign next_head     = (head + DESC_STRIDE == cq_size) ? 32'd0 : head + DESC_STRIDE;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bad_op     = 1'b1;
    status_set = '0;
    case (desc.opcode)
      OP_DMA_COPY, OP_GEMM, OP_EVENT_SIGNAL, OP_EVENT_WAIT: bad_op = 1'b0;
      default: ;
    endcase
    status_set[ST_BAD_OPCODE] = (state == S_DECODE) && bad_op;
    status_set[ST_EVENT]      = ((state == S_DECODE) && (desc.opcode == OP_EVENT_SIGNAL))
                             || ((state == S_COPY) && copy_done)
                             || ((state == S_GEMM) && (gcnt == 2'd0));
    status_set[ST_CQ_EMPTY]   = (state == S_ADVANCE) && (next_head == cq_tail);
  end

  always_comb begin
    mmio_rdata = '0;
    case (mmio_addr)
      REG_CQ_BASE_LO: mmio_rdata = cq_base_lo;
      REG_CQ_BASE_HI: mmio_rdata = cq_base_hi;
      REG_CQ_SIZE:    mmio_rdata = cq_size;
      REG_CQ_HEAD:    mmio_rdata = head;
      REG_CQ_TAIL:    mmio_rdata = cq_tail;
      REG_IRQ_STATUS: mmio_rdata = {{(DATA_W-IRQ_W){1'b0}}, irq_status};
      REG_IRQ_ENABLE: mmio_rdata = {{(DATA_W-IRQ_W){1'b0}}, irq_enable};
      default: ;
    endcase
  end

  // A hardware status set beats a same-cycle write-1-to-clear; a doorbell beats disarm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq_base_lo <= '0;
      cq_base_hi <= '0;
      cq_size    <= '0;
      cq_tail    <= '0;
      irq_enable <= '0;
      irq_status <= '0;
      armed      <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~status_clr) | status_set;
      armed      <= doorbell | (armed & ~status_set[ST_CQ_EMPTY]);
      if (mmio_we) begin
        case (mmio_addr)
          REG_CQ_BASE_LO: cq_base_lo <= mmio_wdata;
          REG_CQ_BASE_HI: cq_base_hi <= mmio_wdata;
          REG_CQ_SIZE:    cq_size    <= mmio_wdata;
          REG_CQ_TAIL:    cq_tail    <= mmio_wdata;
          REG_IRQ_ENABLE: irq_enable <= mmio_wdata[IRQ_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      desc          <= '0;
      head          <= '0;
      events        <= '0;
      gcnt          <= '0;
      dma_req_valid <= 1'b0;
      copy_start    <= 1'b0;
    end else begin
      copy_start <= 1'b0;
      case (state)
        S_IDLE:   if (armed && head != cq_tail) state <= S_FETCH;
        S_FETCH: begin
          desc  <= unpack_desc(cq_mem_rdata);
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (desc.opcode)
            OP_DMA_COPY: begin
              dma_req_valid <= 1'b1;
              state         <= S_DMA_REQ;
            end
            OP_GEMM: begin
              gcnt  <= 2'd3;
              state <= S_GEMM;
            end
            OP_EVENT_SIGNAL: begin
              events[desc.arg[2:0]] <= 1'b1;
              state                 <= S_ADVANCE;
            end
            OP_EVENT_WAIT: state <= S_EVT_WAIT;
            default:       state <= S_ADVANCE;
          endcase
        end
        S_DMA_REQ: if (dma_req_ready) begin
          dma_req_valid <= 1'b0;
          copy_start    <= 1'b1;
          state         <= S_COPY;
        end
        S_COPY:   if (copy_done) state <= S_ADVANCE;
        S_GEMM: begin
          if (gcnt == 2'd0) state <= S_ADVANCE;
          else              gcnt  <= gcnt - 2'd1;
        end
        S_EVT_WAIT: if (events[desc.arg[2:0]]) begin
          events[desc.arg[2:0]] <= 1'b0;
          state                 <= S_ADVANCE;
        end
        S_ADVANCE: begin
          head  <= next_head;
          state <= (next_head == cq_tail) ? S_IDLE : S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  npu_axi_copy u_copy (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (copy_start),
    .src           (desc.src),
    .dst           (desc.dst),
    .bytes         (desc.bytes),
    .done          (copy_done),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata)
  );

endmodule

// File: tb/tb_npu_shell_top.sv
// Directed self-checking bench for npu_shell_top with a reactive AXI/CQ
// memory model; expected values are hand-computed per step.
module tb_npu_shell_top;
  import npu_shell_pkg::*;

  localparam logic [63:0] CQ_BASE    = 64'h0000_0002_0000_0000;
  localparam logic [63:0] SRAM_BASE0 = 64'h0000_0000_4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] mmio_addr = '0;
  logic mmio_we = 1'b0;
  logic [31:0] mmio_wdata = '0;
  logic [31:0] mmio_rdata;
  logic irq, dma_req_valid, dma_req_ready, dma_resp_done;
  logic [63:0] dma_req_src, dma_req_dst, cq_mem_addr, cq_off;
  logic [31:0] dma_req_bytes;
  logic [255:0] cq_mem_rdata;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [63:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_arsize;
  logic [255:0] m_axi_wdata, m_axi_rdata;
  logic [31:0] m_axi_wstrb;

  logic [255:0] cq [0:7];
  logic [255:0] mem [bit [63:0]];
  logic [255:0] merged;
  logic [63:0] r_addr, w_addr;
  logic r_pend, b_pend, auto_ready;
  int ar_count, aw_count, req_count, w_bad;
  logic [31:0] last_wstrb;
  int n_tests = 0;
  int n_fail = 0;

  assign dma_resp_done = 1'b0;
  assign m_axi_arready = 1'b1;
  assign m_axi_awready = 1'b1;
  assign m_axi_wready  = 1'b1;
  assign cq_off        = cq_mem_addr - CQ_BASE;
  assign cq_mem_rdata  = cq[cq_off[7:5]];

  always #5 clk = ~clk;

  npu_shell_top dut (
    .clk(clk), .rst_n(rst_n),
    .mmio_addr(mmio_addr), .mmio_we(mmio_we), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .irq(irq),
    .dma_req_valid(dma_req_valid), .dma_req_src(dma_req_src), .dma_req_dst(dma_req_dst),
    .dma_req_bytes(dma_req_bytes), .dma_req_ready(dma_req_ready), .dma_resp_done(dma_resp_done),
    .cq_mem_addr(cq_mem_addr), .cq_mem_rdata(cq_mem_rdata),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast)
  );

  // Source contents are a function of the beat address; only written beats are stored.
  function automatic logic [255:0] pat(input logic [63:0] a);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = a[31:0] + 32'(i) * 32'h0101_0101 + 32'h5A5A_0000 ^ a[63:32];
    return v;
  endfunction

  function automatic logic [255:0] read_beat(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction

  function automatic int region_errors(input logic [63:0] dst, input logic [63:0] src, input int beats);
    int errs = 0;
    for (int k = 0; k < beats; k++)
      if (read_beat(dst + 64'(32 * k)) !== pat(src + 64'(32 * k))) errs++;
    return errs;
  endfunction

  // Always-ready AXI slave: one read beat per AR, one B per W, answered at negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0; m_axi_bvalid = 1'b0;
      r_pend = 1'b0; b_pend = 1'b0; r_addr = '0; w_addr = '0; dma_req_ready = 1'b0;
      ar_count = 0; aw_count = 0; req_count = 0; w_bad = 0; last_wstrb = '0;
    end else begin
      dma_req_ready = auto_ready && dma_req_valid;
      if (dma_req_valid && dma_req_ready) req_count++;
      if (m_axi_rvalid) begin
        m_axi_rvalid = 1'b0; r_pend = 1'b0;
      end else if (r_pend && m_axi_rready) begin
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = read_beat(r_addr);
      end
      if (m_axi_arvalid) begin
        r_pend = 1'b1; r_addr = m_axi_araddr; ar_count++;
        if (m_axi_arlen != 8'd0) w_bad++;
      end
      if (m_axi_bvalid) m_axi_bvalid = 1'b0;
      else if (b_pend && m_axi_bready) begin m_axi_bvalid = 1'b1; b_pend = 1'b0; end
      if (m_axi_awvalid) begin w_addr = m_axi_awaddr; aw_count++; end
      if (m_axi_wvalid) begin
        merged = read_beat(w_addr);
        for (int i = 0; i < 32; i++) if (m_axi_wstrb[i]) merged[8*i +: 8] = m_axi_wdata[8*i +: 8];
        mem[w_addr] = merged; last_wstrb = m_axi_wstrb; b_pend = 1'b1;
        if (!m_axi_wlast) w_bad++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mmio_write(input logic [11:0] a, input logic [31:0] d);
    mmio_addr = a; mmio_wdata = d; mmio_we = 1'b1;
    @(negedge clk);
    mmio_we = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [11:0] a, input logic [31:0] exp);
    mmio_addr = a;
    #1;
    check(tag, 64'(mmio_rdata), 64'(exp));
  endtask

  task automatic do_reset();
    mmio_we = 1'b0; auto_ready = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mmio_write(REG_CQ_BASE_LO, CQ_BASE[31:0]);
    mmio_write(REG_CQ_BASE_HI, CQ_BASE[63:32]);
  endtask

  task automatic set_desc(input int idx, input logic [7:0] op, input logic [7:0] arg,
                          input logic [63:0] src, input logic [63:0] dst, input logic [31:0] n);
    logic [255:0] d = '0;
    d[7:0] = op; d[23:16] = arg; d[127:64] = src; d[191:128] = dst; d[223:192] = n;
    cq[idx] = d;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    logic ok = 1'b0;
    mmio_addr = REG_IRQ_STATUS;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = mmio_rdata[ST_CQ_EMPTY];
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    logic found;
    for (int i = 0; i < 8; i++) cq[i] = '0;
    auto_ready = 1'b1;

    // 1: reset state
    do_reset();
    rst_n = 1'b0; #1;
    check_reg("rst_doorbell", REG_DOORBELL, 32'h0);
    check_reg("rst_base_lo", REG_CQ_BASE_LO, 32'h0);
    check_reg("rst_base_hi", REG_CQ_BASE_HI, 32'h0);
    check_reg("rst_size", REG_CQ_SIZE, 32'h0);
    check_reg("rst_head", REG_CQ_HEAD, 32'h0);
    check_reg("rst_tail", REG_CQ_TAIL, 32'h0);
    check_reg("rst_status", REG_IRQ_STATUS, 32'h0);
    check_reg("rst_enable", REG_IRQ_ENABLE, 32'h0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_valids", 64'({dma_req_valid, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
    check("rst_size_len", 64'({m_axi_awsize, m_axi_arsize, m_axi_awlen, m_axi_arlen}), 64'({3'd5, 3'd5, 8'd0, 8'd0}));

    // 2: single 4 KiB DMA_COPY with a manual request handshake
    do_reset();
    auto_ready = 1'b0;
    set_desc(0, OP_DMA_COPY, 8'd0, 64'h0, 64'h10_0000, 32'd4096);
    mmio_write(REG_CQ_TAIL, 32'd32);
    mmio_write(REG_DOORBELL, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      found = dma_req_valid;
    end
    check("t2_req_valid", 64'(found), 64'd1);
    check("t2_req_src", dma_req_src, 64'h0);
    check("t2_req_dst", dma_req_dst, 64'h10_0000);
    check("t2_req_bytes", 64'(dma_req_bytes), 64'd4096);
    repeat (3) @(negedge clk);
    check("t2_req_held", 64'({dma_req_valid, m_axi_arvalid}), 64'b10);
    auto_ready = 1'b1;
    wait_empty("t2_finish", 4000);
    check("t2_ar_beats", 64'(ar_count), 64'd128);
    check("t2_aw_beats", 64'(aw_count), 64'd128);
    check("t2_data", 64'(region_errors(64'h10_0000, 64'h0, 128)), 64'd0);
    check("t2_wstrb", 64'(last_wstrb), 64'hFFFF_FFFF);
    check("t2_protocol", 64'(w_bad), 64'd0);
    check_reg("t2_status", REG_IRQ_STATUS, 32'b011);
    check_reg("t2_head", REG_CQ_HEAD, 32'd32);

    // 3: chained copy through SRAM
    do_reset();
    set_desc(0, OP_DMA_COPY, 8'd0, 64'h0, SRAM_BASE0, 32'd256);
    set_desc(1, OP_DMA_COPY, 8'd0, SRAM_BASE0, 64'h1_0000, 32'd256);
    mmio_write(REG_CQ_TAIL, 32'd64);
    mmio_write(REG_DOORBELL, 32'd1);
    wait_empty("t3_finish", 1000);
    check("t3_data", 64'(region_errors(64'h1_0000, 64'h0, 8)), 64'd0);
    check("t3_reqs", 64'(req_count), 64'd2);
    check_reg("t3_head", REG_CQ_HEAD, 32'd64);
    check_reg("t3_status", REG_IRQ_STATUS, 32'b011);

    // 4: GEMM, EVENT_SIGNAL(1), EVENT_WAIT(1)
    do_reset();
    set_desc(0, OP_GEMM, 8'd0, 64'h0, 64'h0, 32'd0);
    set_desc(1, OP_EVENT_SIGNAL, 8'd1, 64'h0, 64'h0, 32'd0);
    set_desc(2, OP_EVENT_WAIT, 8'd1, 64'h0, 64'h0, 32'd0);
    mmio_write(REG_CQ_TAIL, 32'd96);
    mmio_write(REG_DOORBELL, 32'd1);
    wait_empty("t4_finish", 200);
    check("t4_no_dma", 64'(req_count + ar_count), 64'd0);
    check_reg("t4_head", REG_CQ_HEAD, 32'd96);
    check_reg("t4_status", REG_IRQ_STATUS, 32'b011);

    // 5: unknown opcode, W1C and irq masking
    do_reset();
    set_desc(0, 8'h7F, 8'd0, 64'h0, 64'h0, 32'd0);
    mmio_write(REG_CQ_TAIL, 32'd32);
    mmio_write(REG_DOORBELL, 32'd1);
    wait_empty("t5_finish", 200);
    check_reg("t5_status_bad", REG_IRQ_STATUS, 32'b101);
    check("t5_irq_masked", 64'(irq), 64'd0);
    mmio_write(REG_IRQ_ENABLE, 32'h4);
    check("t5_irq_bad", 64'(irq), 64'd1);
    mmio_write(REG_IRQ_STATUS, 32'h4);
    check_reg("t5_status_w1c", REG_IRQ_STATUS, 32'b001);
    check("t5_irq_cleared", 64'(irq), 64'd0);
    mmio_write(REG_IRQ_ENABLE, 32'h1);
    check("t5_irq_empty", 64'(irq), 64'd1);

    // 6: head wrap at CQ_SIZE, with a 40-byte partial copy
    do_reset();
    mmio_write(REG_CQ_SIZE, 32'd64);
    set_desc(0, OP_GEMM, 8'd0, 64'h0, 64'h0, 32'd0);
    set_desc(1, OP_DMA_COPY, 8'd0, 64'h3000, 64'h20_0000, 32'd40);
    mmio_write(REG_CQ_TAIL, 32'd32);
    mmio_write(REG_DOORBELL, 32'd1);
    wait_empty("t6_first", 200);
    check_reg("t6_head_mid", REG_CQ_HEAD, 32'd32);
    mmio_write(REG_IRQ_STATUS, 32'h7);
    check_reg("t6_status_clr", REG_IRQ_STATUS, 32'h0);
    mmio_write(REG_CQ_TAIL, 32'd0);
    mmio_write(REG_DOORBELL, 32'd1);
    wait_empty("t6_wrap", 500);
    check_reg("t6_head_wrap", REG_CQ_HEAD, 32'd0);
    check_reg("t6_status", REG_IRQ_STATUS, 32'b011);
    check("t6_beats", 64'(aw_count), 64'd2);
    check("t6_last_strb", 64'(last_wstrb), 64'h0000_00FF);
    check("t6_beat0", 64'(region_errors(64'h20_0000, 64'h3000, 1)), 64'd0);
    merged = read_beat(64'h20_0020);
    check("t6_beat1_lo", merged[63:0], pat(64'h3020) >> 0 & 256'hFFFF_FFFF_FFFF_FFFF);

    // 7: async reset during a burst drops every valid at once
    do_reset();
    set_desc(0, OP_DMA_COPY, 8'd0, 64'h0, 64'h30_0000, 32'd4096);
    mmio_write(REG_CQ_TAIL, 32'd32);
    mmio_write(REG_DOORBELL, 32'd1);
    repeat (40) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = m_axi_awvalid;
    end
    check("t7_in_burst", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_valids_drop", 64'({dma_req_valid, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
    check_reg("t7_head", REG_CQ_HEAD, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
